// File: rtl/act_feeder_pkg.sv
// Shared types and constants for the activation row feeder.
// The optional stall counter is enabled with the ACT_FEEDER_STALL_CNT_EN macro.
package act_feeder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      SWEEP = 2'd2,
      DONE  = 2'd3
   } feeder_state_e;

   // Default geometry (VGG16 first-layer sized)
   localparam int DEF_MAX_W = 224;
   localparam int DEF_MAX_H = 224;

   // Column step runs 0..W+1, so it needs room for MAX_W+1
   localparam int COL_CNT_W = $clog2(DEF_MAX_W + 2);
   // Row counter runs 0..H and must hold the latched height
   localparam int ROW_CNT_W = $clog2(DEF_MAX_H + 1);

   // Value driven on the zero-padding border
   localparam int PAD_VALUE = 0;

   // Width helpers for non-default geometries
   function automatic int col_cnt_w(input int max_w);
      return $clog2(max_w + 2);
   endfunction

   function automatic int row_cnt_w(input int max_h);
      return $clog2(max_h + 1);
   endfunction

endpackage

// File: rtl/act_line_buffer.sv
// One image line of activations: synchronous write, combinational read.
// A write and a read to the same address in one cycle returns the old data.
module act_line_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 224,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Storage write; contents need no reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/act_row_feeder.sv
// Producer for the 3x3 activation patch shifter.
// Buffers two lines of a raster stream and emits (r-1, r, r+1) columns with
// one pixel of zero padding on every side. Optional stall counter output is
// enabled by defining ACT_FEEDER_STALL_CNT_EN.
module act_row_feeder
   import act_feeder_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int MAX_W      = DEF_MAX_W,
   parameter int MAX_H      = DEF_MAX_H
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
   input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        data_first_row,
   output logic [DATA_WIDTH-1:0]        data_second_row,
   output logic [DATA_WIDTH-1:0]        data_third_row,
   output logic                         act_load,
   output logic                         patch_valid,
   output logic [$clog2(MAX_H)-1:0]     out_row,
   output logic [$clog2(MAX_W)-1:0]     out_col,
   output logic                         busy,
   output logic                         done
`ifdef ACT_FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]                  stall_cnt
`endif
);

   localparam int KW  = col_cnt_w(MAX_W);
   localparam int RW  = row_cnt_w(MAX_H);
   localparam int AW  = $clog2(MAX_W);
   localparam int ORW = $clog2(MAX_H);
   localparam int OCW = $clog2(MAX_W);
   localparam logic [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(PAD_VALUE);

   feeder_state_e state, nxt;

   logic [KW-1:0] w_q;      // latched width
   logic [RW-1:0] h_q;      // latched height
   logic [KW-1:0] k;        // column step 0..W+1
   logic [RW-1:0] r;        // output row
   logic [KW-1:0] pcnt;     // prime write pointer
   logic          sel;      // which buffer holds the current row

   logic                         adv;
   logic [1:0]                   wr_en;
   logic [AW-1:0]                wr_addr;
   logic [AW-1:0]                rd_addr;
   logic [1:0][DATA_WIDTH-1:0]   rd_data;
   logic [DATA_WIDTH-1:0]        col_first, col_second, col_third;

   logic inner, has_below, consume, last_col, last_row;

   assign inner     = (k != '0) && (k <= w_q);
   assign has_below = (r != h_q - RW'(1));
   assign last_row  = ~has_below;
   assign last_col  = (k == w_q + KW'(1));
   assign consume   = (state == SWEEP) && inner && has_below;
   assign rd_addr   = AW'(k - KW'(1));

   // Two line buffers; cur/prev roles swap at the end of each row
   for (genvar i = 0; i < 2; i++) begin : gen_lb
      act_line_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (MAX_W)
      ) u_lb (
         .clk   (clk),
         .we    (wr_en[i]),
         .waddr (wr_addr),
         .wdata (in_data),
         .raddr (rd_addr),
         .rdata (rd_data[i])
      );
   end

   // Next state, handshake, buffer writes and the column being presented
   always_comb begin
      nxt        = state;
      in_ready   = 1'b0;
      adv        = 1'b0;
      wr_en      = 2'b00;
      wr_addr    = rd_addr;
      col_first  = PAD;
      col_second = PAD;
      col_third  = PAD;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) nxt = PRIME;
         end
         PRIME: begin
            in_ready   = 1'b1;
            wr_addr    = AW'(pcnt);
            wr_en[sel] = in_valid;
            if (in_valid && (pcnt == w_q - KW'(1))) nxt = SWEEP;
         end
         SWEEP: begin
            if (consume) begin
               in_ready    = out_ready;
               adv         = in_valid && out_ready;
               // the row below overwrites the top row after it was read
               wr_en[~sel] = adv;
            end else begin
               adv = out_ready;
            end
            if (inner) begin
               col_first  = (r == '0) ? PAD : rd_data[~sel];
               col_second = rd_data[sel];
               col_third  = has_below ? in_data : PAD;
            end
            if (adv && last_col && last_row) nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // FSM state, configuration latch and position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         w_q   <= '0;
         h_q   <= '0;
         k     <= '0;
         r     <= '0;
         pcnt  <= '0;
         sel   <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  w_q  <= KW'(cfg_width);
                  h_q  <= RW'(cfg_height);
                  k    <= '0;
                  r    <= '0;
                  pcnt <= '0;
               end
            end
            PRIME: begin
               if (in_valid) pcnt <= pcnt + KW'(1);
            end
            SWEEP: begin
               if (adv) begin
                  if (last_col) begin
                     k <= '0;
                     r <= r + RW'(1);
                     if (has_below) sel <= ~sel;
                  end else begin
                     k <= k + KW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Output column register; data holds between loads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_first_row  <= '0;
         data_second_row <= '0;
         data_third_row  <= '0;
         act_load        <= 1'b0;
         patch_valid     <= 1'b0;
         out_row         <= '0;
         out_col         <= '0;
      end else begin
         act_load    <= adv;
         patch_valid <= adv && (k >= KW'(2));
         if (adv) begin
            data_first_row  <= col_first;
            data_second_row <= col_second;
            data_third_row  <= col_third;
         end
         // window centre trails the loaded column by two
         if (adv && (k >= KW'(2))) begin
            out_row <= ORW'(r);
            out_col <= OCW'(k - KW'(2));
         end
      end
   end

`ifdef ACT_FEEDER_STALL_CNT_EN
   // Saturating count of SWEEP cycles that did not advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if ((state == IDLE) && start) begin
         stall_cnt <= '0;
      end else if ((state == SWEEP) && !adv && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/act_row_feeder.md
Name: act_row_feeder

Overview:
- Producer side of the 3x3 activation patch register file.
- Accepts a raster-order activation stream for one feature-map channel and buffers two lines internally.
- Drives three vertically aligned pixels (top, middle and bottom rows) per column, with a one-cycle act_load pulse, so the downstream 3x3 shifter holds a centered window.
- Applies 1-pixel zero padding (VGG16 "same" conv) and flags when the downstream window is complete.

Parameters:
- DATA_WIDTH, 16, activation width.
- MAX_W, 224, maximum image width (line-buffer depth).
- MAX_H, 224, maximum image height.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height; ignored unless IDLE
- cfg_width  in  $clog2(MAX_W+1)  image width W, 1..MAX_W
- cfg_height  in  $clog2(MAX_H+1)  image height H, 1..MAX_H
- in_data  in  DATA_WIDTH  input activation, raster order
- in_valid  in  1  input valid
- in_ready  out  1  input accepted when in_valid&&in_ready
- out_ready  in  1  downstream may accept a column this cycle (stall when low)
- data_first_row  out  DATA_WIDTH  top-row pixel (r-1)
- data_second_row  out  DATA_WIDTH  middle-row pixel (r)
- data_third_row  out  DATA_WIDTH  bottom-row pixel (r+1)
- act_load  out  1  column valid pulse; shifter captures on this cycle's edge
- patch_valid  out  1  shifter holds a complete window centered at (out_row,out_col)
- out_row  out  $clog2(MAX_H)  window center row
- out_col  out  $clog2(MAX_W)  window center column
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after the last column of the last row

Behaviour:
- Reset: every output is 0; FSM returns to IDLE; counters are cleared. Reset mid-frame abandons the frame; line-buffer contents are don't-care.
- Latched configuration: W and H are captured at start. Out-of-range values (0 or greater than the maximum) are unsupported and not checked.
- IDLE: in_ready=0. On start, go to PRIME.
- PRIME:
  - in_ready=1. Write row 0 into line buffer B[cur] at addresses 0..W-1.
  - After W accepted beats, go to SWEEP with r=0, k=0.
- SWEEP, one column step per "advance" (column index k=0..W+1):
  - k=0 and k=W+1: advance when out_ready. All three data outputs are 0 (pad).
  - 1<=k<=W:
    - first = B[prev][k-1], or 0 when r=0.
    - second = B[cur][k-1].
    - third = in_data when r<H-1, else 0.
  - Input consumption when r<H-1 and 1<=k<=W:
    - in_ready = out_ready.
    - Advance only on in_valid && out_ready.
    - The accepted pixel is written to B[prev][k-1] in the same cycle (read-before-write to the same address).
  - Otherwise in_ready=0 and advance = out_ready.
  - After k=W+1: swap cur/prev (only when r<H-1), r++, k=0. After r=H-1, go to DONE.
- Output registers: on an advance, data_* and act_load=1 are registered next cycle. With no advance, act_load=0 and data_* hold.
- patch_valid: asserted on the cycle after a load with k>=2, i.e. coincident with the shifter's updated contents. Then out_row=r and out_col=k-2. Each row yields exactly W patch_valid pulses; the frame yields W*H.
- DONE: done=1 for one cycle, then IDLE.
- Stalls: out_ready low or in_valid low mid-row inserts bubbles only; no data is lost or duplicated.
- Degenerate sizes: W=1 gives 3 loads per row. H=1 consumes only the primed row.

Optional Feature:
- ACT_FEEDER_STALL_CNT_EN:
  - Defined: adds output stall_cnt, 32 bits. It counts SWEEP cycles with no advance, clears on start, saturates at all-ones, and holds its value in IDLE.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package act_feeder_pkg holds:
  - the FSM state enum (IDLE, PRIME, SWEEP, DONE);
  - the localparams for counter widths derived from MAX_W/MAX_H;
  - the pad value constant (0).
- One sub-module, act_line_buffer: MAX_W x DATA_WIDTH, one synchronous write port, one combinational read port. Two instances, selected by a cur/prev toggle bit.

Test Plan:
- W=4, H=3, pixel(r,c)=16r+c+1, out_ready=1, in_valid=1:
  - expect 18 act_load pulses;
  - row 0: the k=1 load gives (0,1,17), the k=4 load gives (0,4,20);
  - 12 patch_valid pulses with (out_row,out_col) stepping (0,0)..(2,3);
  - one done pulse.
- Same frame, last row (r=2), k=1 load: expect (17,33,0). The k=0 and k=5 loads are (0,0,0).
- out_ready toggling 1,0 every cycle: act_load never fires while out_ready is low during the preceding cycle; the value sequence is identical to the first test.
- in_valid low for 5 cycles mid row 1: in_ready asserted, no act_load, outputs hold; the sequence resumes without skipped or duplicated pixels.
- W=1, H=1, pixel=7: prime consumes 1 beat; loads are (0,0,0), (0,7,0), (0,0,0); one patch_valid at (0,0); done.
- Assert rst_n low mid-SWEEP: outputs go to 0 immediately and the FSM goes to IDLE. A new start with W=4, H=3 reproduces the first test exactly.
